// File: rtl/mul_seq_param.sv
// Iterative signed/unsigned multiplier: retires BPC multiplier bits per cycle into a 2*WIDTH accumulator,
// then applies the result sign and returns the selected half of the full product.
module mul_seq_param #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_signed,
    input  logic             b_signed,
    input  logic             upper,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             drdy
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // S_ZERO is the single idle-looking cycle of the zero-operand early-out.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_NEG,
        S_ZERO,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 upper_q, upper_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   pp_sum;
    logic [2*WIDTH-1:0]   prod;

    always_comb begin
        a_neg = a_signed & a[WIDTH-1];
        b_neg = b_signed & b[WIDTH-1];
        a_mag = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag = b_neg ? (~b + WIDTH'(1)) : b;

        pp_sum = '0;
        for (int j = 0; j < BPC; j++) begin
            if (mplier_q[j]) begin
                pp_sum = pp_sum + (mcand_q << j);
            end
        end

        prod = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        upper_d  = upper_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    upper_d  = upper;
                    neg_d    = a_neg ^ b_neg;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    cnt_d    = CW'(N - 1);
                    if (a == '0 || b == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d    = acc_q + pp_sum;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_NEG;
                end
            end
            S_NEG: begin
                // Half select is taken from the signed product, never from the magnitude.
                dout_d  = upper_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
                state_d = S_DONE;
            end
            S_ZERO: begin
                dout_d  = '0;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            dout_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            upper_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            upper_q  <= upper_d;
        end
    end

    assign busy = (state_q == S_CALC) || (state_q == S_NEG);
    assign drdy = (state_q == S_DONE);
    assign dout = dout_q;

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: three instances (BPC=1,2,4) share stimulus and are checked every cycle
// against a transaction-level latency/product model, plus directed literal expectations.
module tb_mul_seq_param;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          a_signed = 1'b0;
    logic          b_signed = 1'b0;
    logic          upper = 1'b0;
    logic [2:0]    busy_w;
    logic [2:0]    drdy_w;
    logic [W-1:0]  dout_w [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mul_seq_param #(.WIDTH(W), .BPC(1 << gi)) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start),
                .a        (a),
                .b        (b),
                .a_signed (a_signed),
                .b_signed (b_signed),
                .upper    (upper),
                .busy     (busy_w[gi]),
                .dout     (dout_w[gi]),
                .drdy     (drdy_w[gi])
            );
        end
    endgenerate

    function automatic int lat_of(int k);
        return W / (1 << k) + 1;
    endfunction

    function automatic logic [W-1:0] ref_out(logic [W-1:0] ta, logic [W-1:0] tb,
                                             logic tas, logic tbs, logic tup);
        logic signed [2*W+1:0] ea, eb, p;
        ea = tas ? {{(W+2){ta[W-1]}}, ta} : {{(W+2){1'b0}}, ta};
        eb = tbs ? {{(W+2){tb[W-1]}}, tb} : {{(W+2){1'b0}}, tb};
        p  = ea * eb;
        return tup ? p[2*W-1:W] : p[W-1:0];
    endfunction

    task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted request occupies the unit for its latency, then presents its result.
    int           m_left [3] = '{0, 0, 0};
    bit           m_zero [3] = '{0, 0, 0};
    bit           m_drdy [3] = '{0, 0, 0};
    logic [W-1:0] m_pend [3] = '{0, 0, 0};
    logic [W-1:0] m_dout [3] = '{0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_left[k] = 0;
                m_zero[k] = 0;
                m_drdy[k] = 0;
                m_dout[k] = '0;
            end else if (m_left[k] == 0 && start) begin
                m_zero[k] = (a == '0) || (b == '0);
                m_left[k] = m_zero[k] ? 1 : lat_of(k);
                m_pend[k] = ref_out(a, b, a_signed, b_signed, upper);
                m_drdy[k] = 0;
            end else if (m_left[k] > 0) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    m_drdy[k] = 1;
                    m_dout[k] = m_pend[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("busy_l%0d", k), W'(busy_w[k]), W'(m_left[k] > 0 && !m_zero[k]));
            check($sformatf("drdy_l%0d", k), W'(drdy_w[k]), W'(m_drdy[k]));
            if (m_drdy[k]) check($sformatf("dout_l%0d", k), dout_w[k], m_dout[k]);
        end
    end

    // One transaction; intr injects an ignored mid-calculation start with different operands.
    task automatic do_op(logic [W-1:0] ta, logic [W-1:0] tb, logic tas, logic tbs, logic tup,
                         logic [W-1:0] exp, bit intr);
        int  lat [3];
        int  c;
        bit  zero;
        lat  = '{0, 0, 0};
        zero = (ta == '0) || (tb == '0);
        @(negedge clk);
        a = ta; b = tb; a_signed = tas; b_signed = tbs; upper = tup; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) check($sformatf("drdy_at_accept_l%0d", k), W'(drdy_w[k]), '0);
        c = 0;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && c < 100) begin
            @(posedge clk); #1;
            c++;
            if (intr && c == 5) begin
                a = ~ta; b = tb + 3; a_signed = ~tas; upper = ~tup; start = 1'b1;
            end
            if (intr && c == 6) start = 1'b0;
            for (int k = 0; k < 3; k++) if (drdy_w[k] && lat[k] == 0) lat[k] = c;
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("latency_l%0d", k), W'(lat[k]), W'(zero ? 1 : lat_of(k)));
            check($sformatf("result_l%0d", k), dout_w[k], exp);
        end
        $display("op a=%08h b=%08h as=%0d bs=%0d up=%0d -> %08h (lat %0d/%0d/%0d)",
                 ta, tb, tas, tbs, tup, dout_w[0], lat[0], lat[1], lat[2]);
    endtask

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   rm;
        bit           seen;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_busy_l%0d", k), W'(busy_w[k]), '0);
            check($sformatf("rst_drdy_l%0d", k), W'(drdy_w[k]), '0);
            check($sformatf("rst_dout_l%0d", k), dout_w[k], '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'd6, 32'd7, 0, 0, 0, 32'h0000_002A, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 32'h0000_0000, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFFE, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 32'hFFFF_FFFF, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0001, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 1, 1, 1, 32'h4000_0000, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 1, 1, 0, 32'h0000_0000, 0);
        do_op(32'hFFFF_FFFD, 32'd5, 1, 0, 0, 32'hFFFF_FFF1, 0);
        do_op(32'd0, 32'h1234_5678, 1, 1, 0, 32'h0000_0000, 0);
        do_op(32'd5, 32'd3, 0, 0, 0, 32'h0000_000F, 0);
        do_op(32'h0000_1234, 32'h0000_0010, 0, 0, 0, 32'h0001_2340, 1);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h0000_5678; a_signed = 0; b_signed = 0; upper = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst_busy_l%0d", k), W'(busy_w[k]), '0);
            check($sformatf("midrst_drdy_l%0d", k), W'(drdy_w[k]), '0);
            check($sformatf("midrst_dout_l%0d", k), dout_w[k], '0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | (|drdy_w);
        end
        check("no_drdy_after_reset", W'(seen), '0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rm = 3'($urandom);
            if (i % 50 == 0)  ra = '0;
            if (i % 50 == 25) rb = '0;
            do_op(ra, rb, rm[0], rm[1], rm[2], ref_out(ra, rb, rm[0], rm[1], rm[2]), 0);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
